dram_port_arbiter: RTL and testbench

//  Shares one 32-bit DRAM port among NUM_REQ requesters (cores/DMA).

---
 rtl/dram_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read DRAM port among NUM_REQ requesters,
// with a bounded lock so one requester can run an atomic read-modify-write sequence.
module dram_port_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 12,
   parameter int LOCK_MAX = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        we_i,
   input  logic [NUM_REQ-1:0]        lock_i,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        rvalid_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic [ADDR_W-1:0]         mem_addr_o,
   output logic                      mem_we_o,
   output logic [DATA_W-1:0]         mem_wdata_o,
   input  logic [DATA_W-1:0]         mem_rdata_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
      if (idx == PTR_LAST) begin
         next_idx = '0;
      end else begin
         next_idx = idx + PTR_ONE;
      end
   endfunction

   logic [0:0]         state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic               found_s;
   logic [PTR_W-1:0]   sel_s;
   logic [PTR_W-1:0]   cand_s;
   logic               grant_v_s;
   logic [PTR_W-1:0]   gidx_s;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic [NUM_REQ-1:0] gnt_s;

   // first requester at or after ptr, wrapping
   always_comb begin
      found_s = 1'b0;
      sel_s   = ptr_q;
      cand_s  = ptr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found_s && req_i[cand_s]) begin
            found_s = 1'b1;
            sel_s   = cand_s;
         end else begin
            found_s = found_s;
         end
         cand_s = next_idx(cand_s);
      end
   end

   always_comb begin
      grant_v_s  = 1'b0;
      gidx_s     = sel_s;
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      cnt_inc_s  = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CNT_ONE;
      case (state_q)
         ST_ARB: begin
            if (found_s) begin
               grant_v_s = 1'b1;
               // a one-cycle lock budget is spent by the granting access itself
               if (lock_i[sel_s] && (LOCK_MAX > 1)) begin
                  state_d    = ST_LOCKED;
                  owner_d    = sel_s;
                  lock_cnt_d = CNT_ONE;
               end else begin
                  ptr_d = next_idx(sel_s);
               end
            end else begin
               grant_v_s = 1'b0;
            end
         end
         ST_LOCKED: begin
            gidx_s     = owner_q;
            grant_v_s  = req_i[owner_q];
            lock_cnt_d = cnt_inc_s;
            if (!lock_i[owner_q] || (cnt_inc_s == CNT_MAX)) begin
               state_d    = ST_ARB;
               ptr_d      = next_idx(owner_q);
               lock_cnt_d = '0;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d    = ST_ARB;
            ptr_d      = '0;
            lock_cnt_d = '0;
         end
      endcase
      if (!rst_n) begin
         grant_v_s = 1'b0;
      end else begin
         grant_v_s = grant_v_s;
      end
   end

   // grant vector, port mux and next read-return values
   always_comb begin
      gnt_s       = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_we_o    = 1'b0;
      rvalid_d    = '0;
      rdata_d     = rdata_q;
      if (grant_v_s) begin
         gnt_s[gidx_s] = 1'b1;
         mem_addr_o    = addr_i[gidx_s*ADDR_W +: ADDR_W];
         mem_wdata_o   = wdata_i[gidx_s*DATA_W +: DATA_W];
         mem_we_o      = we_i[gidx_s];
         if (!we_i[gidx_s]) begin
            rvalid_d = gnt_s;
            rdata_d  = mem_rdata_i;
         end else begin
            rvalid_d = '0;
         end
      end else begin
         gnt_s = '0;
      end
   end

   assign gnt_o    = gnt_s;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;

   // arbitration state and registered read return
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ARB;
         ptr_q      <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         rvalid_q   <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: expected grants are per-step constants, read returns
// come from a scoreboard fed by a bench-side memory model.
module tb_dram_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int LM = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req, we, lock;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_we;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   always #5 clk = ~clk;

   dram_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .lock_i(lock),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   // DRAM stand-in: combinational read, write on posedge
   logic [DW-1:0] dram [0:(1<<AW)-1];
   assign mem_rdata = dram[mem_addr];
   always @(posedge clk) begin
      if (mem_we) dram[mem_addr] <= mem_wdata;
   end

   typedef struct packed {
      logic [N-1:0]  rv;
      logic [DW-1:0] rd;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mdl [0:(1<<AW)-1];
   logic [DW-1:0] rdata_m;
   int            errors = 0;
   int            checks = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
      addr[k*AW +: AW]  = a;
      wdata[k*DW +: DW] = d;
   endtask

   // one clock: check combinational grant/port, queue the read return, check last return
   task automatic cycle(input string tag, input logic [N-1:0] exp_gnt);
      int            g;
      exp_t          e;
      logic [AW-1:0] ga;
      #1;
      chk({tag, " gnt"}, DW'(gnt), DW'(exp_gnt));
      g = -1;
      for (int k = 0; k < N; k++) begin
         if (exp_gnt[k]) g = k;
      end
      e.rv = '0;
      if (g >= 0) begin
         ga = addr[g*AW +: AW];
         chk({tag, " mem_addr"}, DW'(mem_addr), DW'(ga));
         chk({tag, " mem_we"}, DW'(mem_we), DW'(we[g]));
         if (we[g]) begin
            chk({tag, " mem_wdata"}, mem_wdata, wdata[g*DW +: DW]);
            if (rst_n) mdl[ga] = wdata[g*DW +: DW];
         end else begin
            e.rv    = exp_gnt;
            rdata_m = mdl[ga];
         end
      end else begin
         chk({tag, " idle mem_we"}, DW'(mem_we), 32'h0);
         chk({tag, " idle mem_addr"}, DW'(mem_addr), 32'h0);
      end
      if (!rst_n) begin
         e.rv    = '0;
         rdata_m = '0;
      end
      e.rd = rdata_m;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, " rvalid"}, DW'(rvalid), DW'(e.rv));
         chk({tag, " rdata"}, rdata, e.rd);
      end
   endtask

   initial begin
      logic [N-1:0] one;
      one = 4'b0001;

      // reset with everyone requesting writes
      rst_n = 1'b0; req = 4'b1111; we = 4'b1111; lock = 4'b0000;
      for (int k = 0; k < N; k++) set_req(k, AW'(12'h010 + k), DW'(32'hA0 + k));
      cycle("reset0", 4'b0000);
      cycle("reset1", 4'b0000);

      // preload mem[0x10+k]=0xA0+k, each requester drops after its grant
      rst_n = 1'b1;
      cycle("pre0", 4'b0001);
      req = 4'b1110; cycle("pre1", 4'b0010);
      req = 4'b1100; cycle("pre2", 4'b0100);
      req = 4'b1000; cycle("pre3", 4'b1000);

      // continuous reads from all four rotate 0,1,2,3,0
      we = 4'b0000; req = 4'b1111;
      for (int i = 0; i < 5; i++) cycle("rr_read", N'(one << (i % N)));

      // only 0 and 2 requesting: ptr is 1, so 2 first, then alternate
      req = 4'b0101;
      cycle("alt0", 4'b0100);
      cycle("alt1", 4'b0001);
      cycle("alt2", 4'b0100);
      cycle("alt3", 4'b0001);

      // write by 1 then read of same address by 3 sees new data
      req = 4'b0010; we = 4'b0010;
      set_req(1, 12'h123, 32'hDEADBEEF);
      set_req(3, 12'h123, 32'h0);
      cycle("raw_wr", 4'b0010);
      req = 4'b1000; we = 4'b0000;
      cycle("raw_rd", 4'b1000);
      req = 4'b0000;
      cycle("raw_ret", 4'b0000);
      chk("raw_data", rdata, 32'hDEADBEEF);

      // move ptr to 1, then 1 locks for three accesses while 0 and 2 wait
      set_req(1, 12'h011, 32'h0);
      req = 4'b0001; cycle("lk_pre", 4'b0001);
      req = 4'b0111; lock = 4'b0010;
      cycle("lk1a", 4'b0010);
      cycle("lk1b", 4'b0010);
      lock = 4'b0000;
      cycle("lk1c", 4'b0010);
      req = 4'b0101; cycle("lk_after2", 4'b0100);
      req = 4'b0001; cycle("lk_after0", 4'b0001);

      // lock held indefinitely by 0 is cut off after LOCK_MAX grants
      rst_n = 1'b0; req = 4'b1111; lock = 4'b0001;
      cycle("lm_rst", 4'b0000);
      rst_n = 1'b1;
      for (int i = 0; i < LM; i++) cycle("lm_hold", 4'b0001);
      cycle("lm_next1", 4'b0010);
      cycle("lm_next2", 4'b0100);
      cycle("lm_next3", 4'b1000);
      for (int i = 0; i < 3; i++) cycle("lm_relock", 4'b0001);

      // reset mid-lock with a write pending: no write, ptr back to 0
      rst_n = 1'b0; we = 4'b0001; set_req(0, 12'h010, 32'h55);
      cycle("mid_rst", 4'b0000);
      rst_n = 1'b1; we = 4'b0000; lock = 4'b0000; req = 4'b1110;
      cycle("post_rst1", 4'b0010);
      cycle("post_rst2", 4'b0100);
      req = 4'b0001;
      cycle("no_wr_rd", 4'b0001);
      req = 4'b0000;
      cycle("no_wr_ret", 4'b0000);
      chk("no_wr_data", rdata, 32'hA0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
